pipeif: RTL and testbench

Instruction-fetch stage of the five-stage pipelined CPU, directly upstream of the IF/ID register and decode stage. It owns the fetch PC and drives a variable-latency instruction-memory handshake. It delivers pc4/ins to the IF/ID register and applies redirects (branch, jump, jr) from decode with one architectural delay slot. When no instruction is available, it inserts NOP bubbles instead of stalling decode.

---
 rtl/pipeif_pkg.sv | 23 ++
 rtl/pipenpc.sv | 52 +++++
 rtl/pipeif.sv | 153 +++++++++++++++
 tb/tb_pipeif.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeif_pkg.sv
//------------------------------------------------------------------------------
// pipeif_pkg : shared CPU package (redirect codes, NOP word, fetch FSM states)
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipeif_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [31:0] NOP_INS = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/pipenpc.sv
//------------------------------------------------------------------------------
// pipenpc  : combinational next-PC and redirect-target select for fetch
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipenpc
    import pipeif_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [1:0]  pcsource_i,
    input  logic [31:0] bpc_i,
    input  logic [31:0] ra_i,
    input  logic [31:0] jpc_i,
    input  logic        pend_i,
    input  logic [31:0] pend_tgt_i,
    input  logic        redirect_taken_i,
    output logic [31:0] nxt_o,
    output logic [31:0] tgt_o
);

    localparam logic [31:0] C_ALIGN_MASK = 32'hFFFF_FFFC;

    logic [31:0] w_sel;
    logic [31:0] w_nxt;

    always_comb begin
        w_sel = 32'h0;
        case (pcsource_i)
            PCSRC_BR: w_sel = bpc_i;
            PCSRC_JR: w_sel = ra_i;
            PCSRC_J:  w_sel = jpc_i;
            default:  w_sel = 32'h0;
        endcase
    end

    // A fresh redirect wins over a stored one; pend can only be set when none is taken.
    always_comb begin
        w_nxt = pc_i + 32'd4;
        if (redirect_taken_i) begin
            w_nxt = w_sel;
        end else if (pend_i) begin
            w_nxt = pend_tgt_i;
        end
    end

    assign tgt_o = w_sel & C_ALIGN_MASK;
    assign nxt_o = w_nxt & C_ALIGN_MASK;

endmodule

`default_nettype wire

// File: rtl/pipeif.sv
//------------------------------------------------------------------------------
// pipeif   : instruction-fetch stage with variable-latency imem handshake,
//            delay-slot redirects and NOP bubble insertion.
//            Optional PIPEIF_PERF_CNT_EN adds fetch_cnt / bubble_cnt outputs.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipeif
    import pipeif_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        nostall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] ra,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc4,
    output logic [31:0] ins,
`ifdef PIPEIF_PERF_CNT_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt,
`endif
    output logic [31:0] pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_ins_q, hold_ins_d;
    logic         pend_q, pend_d;
    logic [31:0]  pend_tgt_q, pend_tgt_d;

    logic         w_valid;
    logic         w_deliver;
    logic         w_redirect;
    logic [31:0]  w_nxt;
    logic [31:0]  w_tgt;

    assign w_valid    = (state_q == HOLD) || imem_rdy;
    assign w_deliver  = nostall && w_valid;
    // A redirect arriving while one is pending sits in a delay slot and is dropped.
    assign w_redirect = nostall && (pcsource != PCSRC_SEQ) && !pend_q;

    pipenpc u_npc (
        .pc_i             (pc_q),
        .pcsource_i       (pcsource),
        .bpc_i            (bpc),
        .ra_i             (ra),
        .jpc_i            (jpc),
        .pend_i           (pend_q),
        .pend_tgt_i       (pend_tgt_q),
        .redirect_taken_i (w_redirect),
        .nxt_o            (w_nxt),
        .tgt_o            (w_tgt)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_ins_d = hold_ins_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;

        if (w_deliver) begin
            pc_d   = w_nxt;
            pend_d = 1'b0;
        end else if (w_redirect) begin
            pend_d     = 1'b1;
            pend_tgt_d = w_tgt;
        end

        case (state_q)
            FETCH: begin
                if (imem_rdy && !nostall) begin
                    hold_ins_d = imem_rdata;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (nostall) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            hold_ins_q <= NOP_INS;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_ins_q <= hold_ins_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    // ins is combinational from imem_rdata so zero-wait memory sustains one per cycle.
    always_comb begin
        imem_req  = (state_q == FETCH);
        imem_addr = {pc_q[31:2], 2'b00};
        pc4       = pc_q + 32'd4;
        pc        = pc_q;
        if (state_q == HOLD) begin
            ins = hold_ins_q;
        end else if (imem_rdy && nostall) begin
            ins = imem_rdata;
        end else begin
            ins = NOP_INS;
        end
    end

`ifdef PIPEIF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;
    logic        w_bubble;

    assign w_bubble = nostall && (state_q == FETCH) && !imem_rdy;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            if (w_deliver) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (w_bubble) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeif.sv
//------------------------------------------------------------------------------
// tb_pipeif : directed self-checking bench for the pipeif fetch stage
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipeif;

    logic        clk;
    logic        clrn;
    logic        nostall;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic [31:0] ra;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_rdata;
    logic [31:0] pc4;
    logic [31:0] ins;
    logic [31:0] pc;
`ifdef PIPEIF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    int n_err;
    int n_chk;

    pipeif dut (
        .clk        (clk),
        .clrn       (clrn),
        .nostall    (nostall),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .jpc        (jpc),
        .ra         (ra),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdy   (imem_rdy),
        .imem_rdata (imem_rdata),
        .pc4        (pc4),
        .ins        (ins),
`ifdef PIPEIF_PERF_CNT_EN
        .fetch_cnt  (fetch_cnt),
        .bubble_cnt (bubble_cnt),
`endif
        .pc         (pc)
    );

    // Memory word equals its address; garbage when not ready.
    assign imem_rdata = imem_rdy ? imem_addr : 32'hDEAD_BEEF;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic ns, input logic [1:0] src);
        @(negedge clk);
        imem_rdy = rdy;
        nostall  = ns;
        pcsource = src;
        #1;
    endtask

    initial begin
        n_err    = 0;
        n_chk    = 0;
        nostall  = 1'b1;
        imem_rdy = 1'b0;
        pcsource = 2'b00;
        bpc      = 32'h0;
        jpc      = 32'h0;
        ra       = 32'h0;
        clrn     = 1'b1;
        #1 clrn  = 1'b0;
        #1;
        chk("rst_req",  {31'h0, imem_req}, 32'h1);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc4",  pc4, 32'h4);
        chk("rst_ins",  ins, 32'h0);
        chk("rst_pc",   pc, 32'h0);
        #1 clrn = 1'b1;

        // zero-wait sequential fetch
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 2'b00);
            chk("seq_ins", ins, 32'(i * 4));
            chk("seq_pc4", pc4, 32'(i * 4 + 4));
        end

        // two wait cycles at 0xC
        drive(1'b0, 1'b1, 2'b00);
        chk("w1_ins", ins, 32'h0);
        chk("w1_addr", imem_addr, 32'hC);
        drive(1'b0, 1'b1, 2'b00);
        chk("w2_ins", ins, 32'h0);
        chk("w2_req", {31'h0, imem_req}, 32'h1);
        chk("w2_addr", imem_addr, 32'hC);
        drive(1'b1, 1'b1, 2'b00);
        chk("w3_ins", ins, 32'hC);
        chk("w3_pc4", pc4, 32'h10);

        // stall with response in the first stalled cycle
        drive(1'b1, 1'b0, 2'b00);
        chk("st0_req", {31'h0, imem_req}, 32'h1);
        chk("st0_addr", imem_addr, 32'h10);
        drive(1'b0, 1'b0, 2'b00);
        chk("st1_req", {31'h0, imem_req}, 32'h0);
        chk("st1_ins", ins, 32'h10);
        chk("st1_pc", pc, 32'h10);
        drive(1'b0, 1'b0, 2'b00);
        chk("st2_ins", ins, 32'h10);
        chk("st2_pc", pc, 32'h10);
        drive(1'b0, 1'b1, 2'b00);
        chk("st3_ins", ins, 32'h10);
        chk("st3_pc4", pc4, 32'h14);
        drive(1'b1, 1'b1, 2'b00);
        chk("st4_addr", imem_addr, 32'h14);
        chk("st4_ins", ins, 32'h14);

        // jump to 0x100, then branch at 0x100 to 0x200
        jpc = 32'h100;
        drive(1'b1, 1'b1, 2'b11);
        chk("j_ds_ins", ins, 32'h18);
        drive(1'b1, 1'b1, 2'b00);
        chk("j_tgt_addr", imem_addr, 32'h100);
        chk("j_tgt_ins", ins, 32'h100);
        bpc = 32'h200;
        drive(1'b1, 1'b1, 2'b01);
        chk("b_ds_ins", ins, 32'h104);
        drive(1'b1, 1'b1, 2'b00);
        chk("b_tgt_ins", ins, 32'h200);

        // branch while the delay-slot fetch waits 3 cycles
        drive(1'b1, 1'b1, 2'b00);
        chk("bw_br_ins", ins, 32'h204);
        bpc = 32'h300;
        drive(1'b0, 1'b1, 2'b01);
        chk("bw_w1_ins", ins, 32'h0);
        chk("bw_w1_addr", imem_addr, 32'h208);
        jpc = 32'h900;
        drive(1'b0, 1'b1, 2'b11);
        chk("bw_pend", {31'h0, dut.pend_q}, 32'h1);
        chk("bw_pend_tgt", dut.pend_tgt_q, 32'h300);
        chk("bw_w2_ins", ins, 32'h0);
        drive(1'b0, 1'b1, 2'b00);
        chk("bw_w3_ins", ins, 32'h0);
        chk("bw_w3_addr", imem_addr, 32'h208);
        drive(1'b1, 1'b1, 2'b00);
        chk("bw_ds_ins", ins, 32'h208);
        drive(1'b1, 1'b1, 2'b00);
        chk("bw_pend_clr", {31'h0, dut.pend_q}, 32'h0);
        chk("bw_tgt_ins", ins, 32'h300);

        // pc+4 wraps at the top of the address space
        jpc = 32'hFFFF_FFFC;
        drive(1'b1, 1'b1, 2'b11);
        chk("wr_ds_ins", ins, 32'h304);
        drive(1'b1, 1'b1, 2'b00);
        chk("wr_ins", ins, 32'hFFFF_FFFC);
        chk("wr_pc4", pc4, 32'h0);
        drive(1'b1, 1'b1, 2'b00);
        chk("wr_addr", imem_addr, 32'h0);

        // jr to misaligned ra, then reset mid-wait with a pending redirect
        ra = 32'h1003;
        drive(1'b1, 1'b1, 2'b10);
        chk("jr_ds_ins", ins, 32'h4);
        drive(1'b0, 1'b1, 2'b00);
        chk("jr_addr", imem_addr, 32'h1000);
        chk("jr_ins", ins, 32'h0);
        bpc = 32'h2000;
        drive(1'b0, 1'b1, 2'b01);
        drive(1'b0, 1'b1, 2'b00);
        chk("pre_rst_pend", {31'h0, dut.pend_q}, 32'h1);
        clrn = 1'b0;
        #1;
        chk("mrst_pc", pc, 32'h0);
        chk("mrst_addr", imem_addr, 32'h0);
        chk("mrst_pend", {31'h0, dut.pend_q}, 32'h0);
        chk("mrst_req", {31'h0, imem_req}, 32'h1);
        #1 clrn = 1'b1;
        drive(1'b1, 1'b1, 2'b00);
        chk("post_ins", ins, 32'h0);
        chk("post_pc4", pc4, 32'h4);
        drive(1'b1, 1'b1, 2'b00);
        chk("post_ins2", ins, 32'h4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
